// File: rtl/port_pin_driver.sv
// Pin-side stage behind an 8051 port SFR latch: open-drain pull-down, timed strong pull-up,
// pin-input synchroniser, SFR read mux and synchronised falling-edge flags.
module port_pin_driver #(
  parameter int SYNC_STAGES   = 2,
  parameter int PULLUP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] latch_in,
  input  logic       rmw_read,
  input  logic [7:0] pin_in,
  output logic [7:0] pin_drive_low,
  output logic [7:0] pin_pu_strong,
  output logic [7:0] pin_data,
  output logic [7:0] pin_fall
);

  localparam int CW = $clog2(PULLUP_CYCLES + 1);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULLUP_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES + 1);
  localparam logic [AW-1:0] ARM_ONE  = AW'(1);

  logic [7:0]                  latch_q;
  logic [SYNC_STAGES-1:0][7:0] sync_r;
  logic [7:0]                  sync_q;
  logic [7:0]                  prev_q;
  logic [7:0]                  fall_q;
  logic [AW-1:0]               arm_cnt;
  logic                        armed;

  always_ff @(posedge clock) begin
    if (!reset) begin
      latch_q <= 8'hFF;
    end else begin
      latch_q <= latch_in;
    end
  end

  assign pin_drive_low = ~latch_q;

  // The counter clears on the same edge the latch bit returns to 0, so pull-up and
  // pull-down can never be active together.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pullup
      logic [CW-1:0] cnt;

      always_ff @(posedge clock) begin
        if (!reset) begin
          cnt <= '0;
        end else if (latch_in[gi] && !latch_q[gi]) begin
          cnt <= CNT_LOAD;
        end else if (!latch_in[gi]) begin
          cnt <= '0;
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_ONE;
        end
      end

      assign pin_pu_strong[gi] = (cnt != '0);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{8'hFF}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
    end
  end

  assign sync_q   = sync_r[SYNC_STAGES-1];
  assign pin_data = rmw_read ? latch_q : sync_q;

  // Edge flags stay masked until both sync_q and prev_q hold real pin samples, so the
  // 1s loaded by reset never turn into a falling edge against a low pin.
  assign armed = (arm_cnt == ARM_DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q  <= 8'hFF;
      fall_q  <= 8'h00;
      arm_cnt <= '0;
    end else begin
      prev_q <= sync_q;
      fall_q <= armed ? (prev_q & ~sync_q) : 8'h00;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_ONE;
      end
    end
  end

  assign pin_fall = fall_q;

endmodule

// File: tb/tb_port_pin_driver.sv
// Directed self-checking bench for port_pin_driver with default parameters
// (SYNC_STAGES=2, PULLUP_CYCLES=2).
module tb_port_pin_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] latch_in;
  logic       rmw_read;
  logic [7:0] pin_in;
  logic [7:0] pin_drive_low;
  logic [7:0] pin_pu_strong;
  logic [7:0] pin_data;
  logic [7:0] pin_fall;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  port_pin_driver #(.SYNC_STAGES(2), .PULLUP_CYCLES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .latch_in      (latch_in),
    .rmw_read      (rmw_read),
    .pin_in        (pin_in),
    .pin_drive_low (pin_drive_low),
    .pin_pu_strong (pin_pu_strong),
    .pin_data      (pin_data),
    .pin_fall      (pin_fall)
  );

  always #5 clock = ~clock;

  // One clock edge, then sample 1 time unit later and log the cycle.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    $display("cyc=%0d reset=%b latch_in=%h pin_in=%h rmw=%b drive_low=%h pu=%h data=%h fall=%h",
             cyc, reset, latch_in, pin_in, rmw_read, pin_drive_low, pin_pu_strong, pin_data, pin_fall);
  endtask

  task automatic test_reset();
    reset = 1'b0; latch_in = 8'h00; pin_in = 8'h00; rmw_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (pin_drive_low !== 8'h00) begin bad++; $display("FAIL reset_drive_low got=%h exp=00", pin_drive_low); end
      total++; if (pin_pu_strong !== 8'h00) begin bad++; $display("FAIL reset_pu got=%h exp=00", pin_pu_strong); end
      total++; if (pin_fall !== 8'h00) begin bad++; $display("FAIL reset_fall got=%h exp=00", pin_fall); end
      total++; if (pin_data !== 8'hFF) begin bad++; $display("FAIL reset_data got=%h exp=FF", pin_data); end
    end
    reset = 1'b1;
    step();
    total++; if (pin_drive_low !== 8'hFF) begin bad++; $display("FAIL release_drive_low got=%h exp=FF", pin_drive_low); end
    total++; if (pin_pu_strong !== 8'h00) begin bad++; $display("FAIL release_pu got=%h exp=00", pin_pu_strong); end
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (pin_fall !== 8'h00) begin bad++; $display("FAIL release_no_fall got=%h exp=00", pin_fall); end
    end
    total++; if (pin_data !== 8'h00) begin bad++; $display("FAIL release_data got=%h exp=00", pin_data); end
  endtask

  task automatic test_pullup();
    logic [7:0] exp_pu;
    latch_in = 8'h05;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_pu = (k <= 2) ? 8'h05 : 8'h00;
      total++; if (pin_pu_strong !== exp_pu) begin bad++; $display("FAIL pullup_pu k=%0d got=%h exp=%h", k, pin_pu_strong, exp_pu); end
      total++; if (pin_drive_low !== 8'hFA) begin bad++; $display("FAIL pullup_drive_low k=%0d got=%h exp=FA", k, pin_drive_low); end
      total++; if ((pin_pu_strong & pin_drive_low) !== 8'h00) begin bad++; $display("FAIL pullup_overlap k=%0d got=%h exp=00", k, pin_pu_strong & pin_drive_low); end
    end
    latch_in = 8'h00;
    step();
  endtask

  task automatic test_abort();
    latch_in = 8'h01;
    step();
    total++; if (pin_pu_strong !== 8'h01) begin bad++; $display("FAIL abort_pu_start got=%h exp=01", pin_pu_strong); end
    total++; if (pin_drive_low !== 8'hFE) begin bad++; $display("FAIL abort_drive_low got=%h exp=FE", pin_drive_low); end
    latch_in = 8'h00;
    step();
    total++; if (pin_pu_strong !== 8'h00) begin bad++; $display("FAIL abort_pu_cut got=%h exp=00", pin_pu_strong); end
    total++; if (pin_drive_low !== 8'hFF) begin bad++; $display("FAIL abort_drive_back got=%h exp=FF", pin_drive_low); end
    step();
    total++; if (pin_pu_strong !== 8'h00) begin bad++; $display("FAIL abort_pu_stay got=%h exp=00", pin_pu_strong); end
    latch_in = 8'h01;
    step();
    total++; if (pin_pu_strong !== 8'h01) begin bad++; $display("FAIL restart_pu1 got=%h exp=01", pin_pu_strong); end
    step();
    total++; if (pin_pu_strong !== 8'h01) begin bad++; $display("FAIL restart_pu2 got=%h exp=01", pin_pu_strong); end
    step();
    total++; if (pin_pu_strong !== 8'h00) begin bad++; $display("FAIL restart_pu_end got=%h exp=00", pin_pu_strong); end
    latch_in = 8'h00;
    step();
  endtask

  task automatic test_fall();
    logic [7:0] exp_fall;
    rmw_read = 1'b0;
    pin_in = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (pin_fall !== 8'h00) begin bad++; $display("FAIL rise_no_fall k=%0d got=%h exp=00", k, pin_fall); end
    end
    pin_in = 8'h7F;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_fall = (k == 3) ? 8'h80 : 8'h00;
      total++; if (pin_fall !== exp_fall) begin bad++; $display("FAIL fall7 k=%0d got=%h exp=%h", k, pin_fall, exp_fall); end
      if (k == 2) begin
        total++; if (pin_data !== 8'h7F) begin bad++; $display("FAIL sync_latency got=%h exp=7F", pin_data); end
      end
    end
    pin_in = 8'h5A;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_fall = (k == 3) ? 8'h25 : 8'h00;
      total++; if (pin_fall !== exp_fall) begin bad++; $display("FAIL fall_multi k=%0d got=%h exp=%h", k, pin_fall, exp_fall); end
    end
  endtask

  task automatic test_read_mux();
    latch_in = 8'hA5; pin_in = 8'h3C;
    for (int k = 0; k < 3; k++) step();
    rmw_read = 1'b1;
    #1;
    total++; if (pin_data !== 8'hA5) begin bad++; $display("FAIL rmw_latch got=%h exp=A5", pin_data); end
    total++; if (pin_drive_low !== 8'h5A) begin bad++; $display("FAIL mux_drive_low got=%h exp=5A", pin_drive_low); end
    rmw_read = 1'b0;
    #1;
    total++; if (pin_data !== 8'h3C) begin bad++; $display("FAIL rmw_pin got=%h exp=3C", pin_data); end
  endtask

  task automatic test_reset_mid();
    latch_in = 8'h00; pin_in = 8'hFF;
    for (int k = 0; k < 4; k++) step();
    latch_in = 8'h01; pin_in = 8'hFE;
    step();
    total++; if (pin_pu_strong !== 8'h01) begin bad++; $display("FAIL mid_pu1 got=%h exp=01", pin_pu_strong); end
    step();
    total++; if (pin_pu_strong !== 8'h01) begin bad++; $display("FAIL mid_pu2 got=%h exp=01", pin_pu_strong); end
    reset = 1'b0;
    step();
    total++; if (pin_pu_strong !== 8'h00) begin bad++; $display("FAIL mid_reset_pu got=%h exp=00", pin_pu_strong); end
    total++; if (pin_fall !== 8'h00) begin bad++; $display("FAIL mid_reset_fall got=%h exp=00", pin_fall); end
    total++; if (pin_drive_low !== 8'h00) begin bad++; $display("FAIL mid_reset_drive got=%h exp=00", pin_drive_low); end
    total++; if (pin_data !== 8'hFF) begin bad++; $display("FAIL mid_reset_data got=%h exp=FF", pin_data); end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (pin_fall !== 8'h00) begin bad++; $display("FAIL post_reset_fall k=%0d got=%h exp=00", k, pin_fall); end
      total++; if (pin_pu_strong !== 8'h00) begin bad++; $display("FAIL post_reset_pu k=%0d got=%h exp=00", k, pin_pu_strong); end
    end
    total++; if (pin_data !== 8'hFE) begin bad++; $display("FAIL post_reset_data got=%h exp=FE", pin_data); end
  endtask

  initial begin
    test_reset();
    test_pullup();
    test_abort();
    test_fall();
    test_read_mux();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
